// File: rtl/intra4x4_mb_ctrl.sv
// Macroblock sequencer for the intra 4x4 luma PE: walks 16 blocks in z-scan order,
// drives the PE step code, tracks neighbour availability and hands blocks to CAVLC.
module intra4x4_mb_ctrl #(
    parameter int unsigned DCT_LAT  = 3,
    parameter int unsigned IDCT_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h264_reset,
    input  logic       start,
    input  logic [6:0] mb_x,
    input  logic [6:0] mb_y,
    input  logic       cavlc_ready,
    output logic [3:0] next_state,
    output logic [3:0] cur_state,
    output logic [3:0] blk_idx,
    output logic [1:0] blk_x,
    output logic [1:0] blk_y,
    output logic       mbAddrA_valid,
    output logic       mbAddrB_valid,
    output logic       cavlc_valid,
    output logic       busy,
    output logic       mb_done
);

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StLoad      = 4'd1,
        StNext4x4   = 4'd2,
        StTopLeft   = 4'd3,
        StPrepare   = 4'd4,
        StPred      = 4'd5,
        StRes       = 4'd6,
        StDct       = 4'd7,
        StQ         = 4'd8,
        StIq        = 4'd9,
        StIdct      = 4'd10,
        StPreloop   = 4'd11,
        StRenewPix  = 4'd12,
        StWaitCavlc = 4'd13
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] dwell_q, dwell_d;
    logic [3:0] blk_q, blk_d;
    logic [6:0] mb_x_q, mb_y_q;
    logic       a_valid_q, b_valid_q, mb_done_q;
    logic       clear;
    logic       a_valid_d, b_valid_d;

    assign clear = rst | h264_reset;

    always_comb begin
        state_d = StIdle;
        if (!clear) begin
            case (state_q)
                StIdle:            state_d = start ? StLoad : StIdle;
                StLoad, StNext4x4: state_d = StTopLeft;
                StTopLeft:         state_d = StPrepare;
                StPrepare:         state_d = StPred;
                StPred:            state_d = StRes;
                StRes:             state_d = StDct;
                StDct:             state_d = (dwell_q == 4'd0) ? StQ : StDct;
                StQ:               state_d = StIq;
                StIq:              state_d = StIdct;
                StIdct:            state_d = (dwell_q == 4'd0) ? StPreloop : StIdct;
                StPreloop:         state_d = StRenewPix;
                StRenewPix:        state_d = StWaitCavlc;
                StWaitCavlc: begin
                    if (!cavlc_ready)        state_d = StWaitCavlc;
                    else if (blk_q == 4'd15) state_d = StIdle;
                    else                     state_d = StNext4x4;
                end
                default:           state_d = StIdle;
            endcase
        end
    end

    // Dwell counter is loaded one cycle before entering a latency state and counts down to 0.
    always_comb begin
        dwell_d = dwell_q;
        case (state_q)
            StRes:         dwell_d = 4'(DCT_LAT - 1);
            StIq:          dwell_d = 4'(IDCT_LAT - 1);
            StDct, StIdct: if (dwell_q != 4'd0) dwell_d = dwell_q - 4'd1;
            default:       dwell_d = dwell_q;
        endcase
    end

    always_comb begin
        case (state_q)
            StLoad:    blk_d = 4'd0;
            StNext4x4: blk_d = blk_q + 4'd1;
            default:   blk_d = blk_q;
        endcase
    end

    // Availability is computed from the block about to be entered so it is stable from TOPLEFT.
    assign a_valid_d = (blk_d[2] | blk_d[0]) | (mb_x_q != 7'd0);
    assign b_valid_d = (blk_d[3] | blk_d[1]) | (mb_y_q != 7'd0);

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= StIdle;
            dwell_q   <= 4'd0;
            blk_q     <= 4'd0;
            mb_x_q    <= 7'd0;
            mb_y_q    <= 7'd0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            mb_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            blk_q   <= blk_d;
            if (state_q == StIdle && start) begin
                mb_x_q <= mb_x;
                mb_y_q <= mb_y;
            end
            if (state_d == StTopLeft) begin
                a_valid_q <= a_valid_d;
                b_valid_q <= b_valid_d;
            end
            mb_done_q <= (state_q == StWaitCavlc) && cavlc_ready && (blk_q == 4'd15);
        end
    end

    assign next_state    = state_d;
    assign cur_state     = state_q;
    assign blk_idx       = blk_q;
    assign blk_x         = {blk_q[2], blk_q[0]};
    assign blk_y         = {blk_q[3], blk_q[1]};
    assign mbAddrA_valid = a_valid_q;
    assign mbAddrB_valid = b_valid_q;
    assign cavlc_valid   = (state_q == StWaitCavlc);
    assign busy          = (state_q != StIdle);
    assign mb_done       = mb_done_q;

endmodule

// File: tb/tb_intra4x4_mb_ctrl.sv
// Bench for intra4x4_mb_ctrl: two parameterisations share stimulus and are checked against
// a block-schedule reference model, scenario tables and hand-written corner sequences.
module tb_intra4x4_mb_ctrl;

    logic       clk;
    logic       rst, h264_reset, start, cavlc_ready;
    logic [6:0] mb_x, mb_y;

    logic [3:0] ns1, cs1, bi1, ns2, cs2, bi2;
    logic [1:0] bx1, by1, bx2, by2;
    logic       a1, b1, cv1, bz1, dn1, a2, b2, cv2, bz2, dn2;

    intra4x4_mb_ctrl #(.DCT_LAT(3), .IDCT_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .h264_reset(h264_reset), .start(start), .mb_x(mb_x),
        .mb_y(mb_y), .cavlc_ready(cavlc_ready), .next_state(ns1), .cur_state(cs1),
        .blk_idx(bi1), .blk_x(bx1), .blk_y(by1), .mbAddrA_valid(a1), .mbAddrB_valid(b1),
        .cavlc_valid(cv1), .busy(bz1), .mb_done(dn1)
    );

    intra4x4_mb_ctrl #(.DCT_LAT(1), .IDCT_LAT(5)) dut2 (
        .clk(clk), .rst(rst), .h264_reset(h264_reset), .start(start), .mb_x(mb_x),
        .mb_y(mb_y), .cavlc_ready(cavlc_ready), .next_state(ns2), .cur_state(cs2),
        .blk_idx(bi2), .blk_x(bx2), .blk_y(by2), .mbAddrA_valid(a2), .mbAddrB_valid(b2),
        .cavlc_valid(cv2), .busy(bz2), .mb_done(dn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the per-block step list rather than a state machine.
    typedef struct {
        int st;
        int pos;
        int blk;
        int mbx;
        int mby;
        bit a;
        bit b;
        bit done;
    } mdl_t;

    typedef struct {
        int mbx;
        int mby;
        int sblk;
        int sn;
        int exp_done;
        int exp_xf;
        int exp_a;
        int exp_b;
        int exp_wait;
    } vec_t;

    mdl_t m1, m2;
    int   passed = 0;
    int   total  = 0;
    int   xfer_cnt, a_cnt, b_cnt, wait_cnt, track_blk;

    function automatic int zx(int b);
        return ((b / 4) % 2) * 2 + (b % 4) % 2;
    endfunction

    function automatic int zy(int b);
        return ((b / 4) / 2) * 2 + (b % 4) / 2;
    endfunction

    function automatic int sched_code(int pos, int dl, int il);
        int p;
        if (pos < 4) return 3 + pos;
        p = pos - 4;
        if (p < dl) return 7;
        p = p - dl;
        if (p < 2) return 8 + p;
        p = p - 2;
        if (p < il) return 10;
        p = p - il;
        return 11 + p;
    endfunction

    function automatic mdl_t predict(mdl_t m, bit r, bit hr, bit st, bit rdy, int mbx, int mby,
                                     int dl, int il);
        mdl_t n;
        n = m;
        n.done = 1'b0;
        if (r || hr) begin
            n.st = 0; n.pos = 0; n.blk = 0; n.mbx = 0; n.mby = 0; n.a = 0; n.b = 0;
            return n;
        end
        if (m.st == 0) begin
            if (st) begin
                n.st = 1; n.mbx = mbx; n.mby = mby;
            end
        end else if (m.st == 1 || m.st == 2) begin
            n.blk = (m.st == 1) ? 0 : m.blk + 1;
            n.pos = 0;
            n.st  = 3;
            n.a   = (zx(n.blk) != 0) || (m.mbx != 0);
            n.b   = (zy(n.blk) != 0) || (m.mby != 0);
        end else if (m.st == 13) begin
            if (rdy) begin
                if (m.blk == 15) begin
                    n.st = 0; n.done = 1'b1;
                end else begin
                    n.st = 2;
                end
            end
        end else begin
            n.pos = m.pos + 1;
            n.st  = (n.pos >= 8 + dl + il) ? 13 : sched_code(n.pos, dl, il);
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic chk_dut(input string tag, input logic [3:0] cs, input logic [3:0] bi,
                           input logic [1:0] bx, input logic [1:0] by, input logic a,
                           input logic b, input logic cv, input logic bz, input logic dn,
                           input mdl_t m);
        chk({tag, " cur_state"}, int'(cs), m.st);
        chk({tag, " blk_idx"}, int'(bi), m.blk);
        chk({tag, " blk_x"}, int'(bx), zx(m.blk));
        chk({tag, " blk_y"}, int'(by), zy(m.blk));
        chk({tag, " mbAddrA_valid"}, int'(a), int'(m.a));
        chk({tag, " mbAddrB_valid"}, int'(b), int'(m.b));
        chk({tag, " cavlc_valid"}, int'(cv), int'(m.st == 13));
        chk({tag, " busy"}, int'(bz), int'(m.st != 0));
        chk({tag, " mb_done"}, int'(dn), int'(m.done));
    endtask

    // One clock: check combinational next_state, clock, then check registered outputs.
    task automatic cycle();
        mdl_t p1, p2;
        #1;
        p1 = predict(m1, rst, h264_reset, start, cavlc_ready, int'(mb_x), int'(mb_y), 3, 3);
        p2 = predict(m2, rst, h264_reset, start, cavlc_ready, int'(mb_x), int'(mb_y), 1, 5);
        chk("d1 next_state", int'(ns1), p1.st);
        chk("d2 next_state", int'(ns2), p2.st);
        if (cv1 && cavlc_ready) xfer_cnt++;
        @(posedge clk);
        m1 = p1;
        m2 = p2;
        #1;
        chk_dut("d1", cs1, bi1, bx1, by1, a1, b1, cv1, bz1, dn1, m1);
        chk_dut("d2", cs2, bi2, bx2, by2, a2, b2, cv2, bz2, dn2, m2);
        if (cs1 == 4'd3) begin
            a_cnt += int'(a1);
            b_cnt += int'(b1);
        end
        if (cs1 == 4'd13 && int'(bi1) == track_blk) wait_cnt++;
    endtask

    task automatic run_until_done(input int limit, input int base, output int edges);
        edges = -1;
        for (int k = base; k <= limit; k++) begin
            cycle();
            if (dn1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic run_mb(input vec_t v, output int d1, output int d2);
        int stalls;
        xfer_cnt = 0; a_cnt = 0; b_cnt = 0; wait_cnt = 0; track_blk = v.sblk;
        stalls = 0; d1 = -1; d2 = -1;
        mb_x = 7'(v.mbx); mb_y = 7'(v.mby); start = 1'b1; cavlc_ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            mb_x = 7'($urandom);
            mb_y = 7'($urandom);
            if (m1.st == 13 && m1.blk == v.sblk && stalls < v.sn) begin
                cavlc_ready = 1'b0;
                stalls++;
            end else begin
                cavlc_ready = 1'b1;
            end
            cycle();
            if (dn1 && d1 < 0) d1 = k;
            if (dn2 && d2 < 0) d2 = k;
            if (d1 >= 0 && d2 >= 0) break;
        end
    endtask

    vec_t vecs[6];
    int   exp_tr1[17];
    int   exp_tr2[17];

    initial begin
        int d1, d2, e, found;

        vecs[0] = '{0, 0, 4, 0, 256, 16, 12, 12, 1};
        vecs[1] = '{3, 2, 4, 0, 256, 16, 16, 16, 1};
        vecs[2] = '{0, 0, 4, 5, 261, 16, 12, 12, 6};
        vecs[3] = '{5, 0, 15, 3, 259, 16, 16, 12, 4};
        vecs[4] = '{0, 9, 0, 1, 257, 16, 12, 16, 2};
        vecs[5] = '{127, 127, 10, 2, 258, 16, 16, 16, 3};
        exp_tr1 = '{1, 3, 4, 5, 6, 7, 7, 7, 8, 9, 10, 10, 10, 11, 12, 13, 2};
        exp_tr2 = '{1, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10, 10, 11, 12, 13, 2};

        m1 = '{0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        m2 = m1;
        xfer_cnt = 0; a_cnt = 0; b_cnt = 0; wait_cnt = 0; track_blk = 4;

        // Reset with start asserted: start must be dropped and everything reads 0.
        rst = 1'b1; h264_reset = 1'b0; start = 1'b1; cavlc_ready = 1'b1;
        mb_x = 7'd5; mb_y = 7'd6;
        repeat (3) cycle();
        chk("reset cur_state", int'(cs1), 0);
        chk("reset blk_idx", int'(bi1), 0);
        chk("reset busy", int'(bz1), 0);
        chk("reset next_state", int'(ns1), 0);
        rst = 1'b0; start = 1'b0;
        cycle();

        // Step trace of the first block for both latency settings.
        mb_x = 7'd0; mb_y = 7'd0; start = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cycle();
            start = 1'b0;
            chk("trace d1", int'(cs1), exp_tr1[i]);
            chk("trace d2", int'(cs2), exp_tr2[i]);
        end
        run_until_done(400, 17, e);
        chk("trace mb_done edge", e, 256);
        cycle();

        // Scenario table.
        foreach (vecs[i]) begin
            run_mb(vecs[i], d1, d2);
            chk("tbl done edge d1", d1, vecs[i].exp_done);
            chk("tbl done edge d2", d2, vecs[i].exp_done);
            chk("tbl transfers", xfer_cnt, vecs[i].exp_xf);
            chk("tbl A count", a_cnt, vecs[i].exp_a);
            chk("tbl B count", b_cnt, vecs[i].exp_b);
            chk("tbl wait cycles", wait_cnt, vecs[i].exp_wait);
            cycle();
            chk("tbl idle after", int'(cs1), 0);
        end

        // Soft reset in CNT_IDCT of block 9, then a clean macroblock.
        for (int pass = 0; pass < 2; pass++) begin
            mb_x = 7'd1; mb_y = 7'd1; start = 1'b1; cavlc_ready = 1'b1;
            cycle();
            start = 1'b0;
            found = 0;
            for (int k = 0; k < 400; k++) begin
                if (m1.blk == 9 && m1.st == 10) begin
                    found = 1;
                    break;
                end
                cycle();
            end
            chk("reached blk9 idct", found, 1);
            h264_reset = 1'b1;
            rst = (pass == 1);
            start = 1'b1;
            cycle();
            h264_reset = 1'b0; rst = 1'b0; start = 1'b0;
            chk("softrst cur_state", int'(cs1), 0);
            chk("softrst blk_idx", int'(bi1), 0);
            chk("softrst mb_done", int'(dn1), 0);
            chk("softrst A", int'(a1), 0);
            d1 = 0;
            for (int k = 0; k < 20; k++) begin
                cycle();
                d1 += int'(dn1);
            end
            chk("softrst no done", d1, 0);
            mb_x = 7'd0; mb_y = 7'd0; start = 1'b1;
            cycle();
            start = 1'b0;
            run_until_done(400, 1, e);
            chk("after softrst done edge", e, 256);
        end

        // start re-pulsed while busy at block 7 is ignored.
        start = 1'b1;
        cycle();
        start = 1'b0;
        e = -1;
        for (int k = 1; k <= 400; k++) begin
            start = (m1.blk == 7 && m1.st == 5);
            cycle();
            if (dn1) begin
                e = k;
                break;
            end
        end
        start = 1'b0;
        chk("repulse done edge", e, 256);

        // start held across mb_done: next LOAD one cycle after returning to IDLE.
        cycle();
        start = 1'b1;
        cycle();
        run_until_done(400, 1, e);
        chk("held start done edge", e, 256);
        chk("held start idle", int'(cs1), 0);
        cycle();
        chk("held start reload", int'(cs1), 1);
        chk("held start done cleared", int'(dn1), 0);
        start = 1'b0;
        run_until_done(400, 1, e);
        chk("held start second done", e, 256);

        // Random phase against the model.
        for (int k = 0; k < 3000; k++) begin
            start       = ($urandom_range(7) == 0);
            mb_x        = 7'($urandom);
            mb_y        = 7'($urandom_range(3) == 0 ? 0 : $urandom);
            cavlc_ready = ($urandom_range(3) != 0);
            rst         = ($urandom_range(599) == 0);
            h264_reset  = ($urandom_range(599) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/intra4x4_mb_ctrl.md
Name: intra4x4_mb_ctrl

Overview:
- Macroblock-level sequencer for the intra 4x4 luma processing element.
- Walks the 16 4x4 blocks of one 16x16 macroblock in z-scan order and drives the PE's 4-bit `next_state` step code.
- Derives per-block left/top neighbour availability and holds each block in the DCT/IDCT steps for the pipeline latency.
- Hands each quantised block to CAVLC with a valid/ready handshake and signals macroblock completion.

Parameters:
- DCT_LAT, 3, cycles spent in CNT_DCT (DCT+quant latency), legal range 1..15.
- IDCT_LAT, 3, cycles spent in CNT_IDCT (dequant+IDCT latency), legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- h264_reset  input  1  synchronous active-high encoder soft reset; same effect as rst
- start  input  1  macroblock ready to encode; sampled only in IDLE
- mb_x  input  7  macroblock column; sampled on start
- mb_y  input  7  macroblock row; sampled on start
- cavlc_ready  input  1  CAVLC accepts current block
- next_state  output  4  combinational next value of the state register; step code to the PE
- cur_state  output  4  registered state
- blk_idx  output  4  current 4x4 block, z-scan 0..15
- blk_x  output  2  block column in MB = {blk_idx[2],blk_idx[0]}
- blk_y  output  2  block row in MB = {blk_idx[3],blk_idx[1]}
- mbAddrA_valid  output  1  left neighbour available
- mbAddrB_valid  output  1  top neighbour available
- cavlc_valid  output  1  quantised block ready for CAVLC
- busy  output  1  cur_state != IDLE
- mb_done  output  1  one-cycle pulse, macroblock finished

Behaviour:
- State codes (4 bits):
  - IDLE=0, LOAD=1, NEXT_4x4=2, CNT_TOPLEFT=3, CNT_PREPARE=4, CNT_PRED=5, CNT_RES=6
  - CNT_DCT=7, CNT_Q=8, CNT_IQ=9, CNT_IDCT=10, CNT_PRELOOP=11, RENEW_PIX=12, WAIT_CAVLC=13
  - Codes 14 and 15 are illegal and go to IDLE.
- `next_state` is purely combinational from cur_state, counters and inputs; cur_state <= next_state each clk.
- Transitions:
  - IDLE -> LOAD when start; else stay in IDLE.
  - LOAD -> CNT_TOPLEFT. In LOAD, latch mb_x/mb_y and clear blk_idx.
  - CNT_TOPLEFT -> CNT_PREPARE -> CNT_PRED -> CNT_RES -> CNT_DCT, one cycle each.
  - CNT_DCT: stay DCT_LAT cycles (dwell counter loaded on entry), then -> CNT_Q.
  - CNT_Q -> CNT_IQ -> CNT_IDCT.
  - CNT_IDCT: stay IDCT_LAT cycles, then -> CNT_PRELOOP -> RENEW_PIX -> WAIT_CAVLC.
  - WAIT_CAVLC: stay while !cavlc_ready. When cavlc_ready and blk_idx<15 -> NEXT_4x4; when cavlc_ready and blk_idx==15 -> IDLE.
  - NEXT_4x4: blk_idx increments on this edge; -> CNT_TOPLEFT.
- Neighbour availability, registered, stable from CNT_TOPLEFT through WAIT_CAVLC:
  - mbAddrA_valid = (blk_x!=0) | (mb_x_r!=0)
  - mbAddrB_valid = (blk_y!=0) | (mb_y_r!=0)
- cavlc_valid = (cur_state==WAIT_CAVLC). A transfer occurs on cavlc_valid&cavlc_ready. blk_idx is held throughout.
- mb_done: registered; 1 for exactly the first cycle back in IDLE after block 15 transfers.
- Per-block cycles with cavlc_ready=1 and default params: 15, plus 1 NEXT_4x4 for blocks 0..14.
- Full macroblock latency: start sampled at edge E0 -> cur_state=IDLE and mb_done=1 after edge E0+256.
- start while busy: ignored, no queuing.
- rst or h264_reset, including mid-macroblock: next edge forces cur_state=IDLE, blk_idx=0, dwell=0, mb_x_r=mb_y_r=0, both valids=0, cavlc_valid=0, mb_done=0. `next_state` reads IDLE (0) while the reset is asserted. rst and h264_reset together behave identically to either alone.
- start in the same cycle a reset is asserted: dropped.
- Reset values of all outputs: 0.

Test Plan:
- mb_x=0, mb_y=0, start pulse, cavlc_ready=1:
  - cur_state steps 1,3,4,5,6,7,7,7,8,9,10,10,10,11,12,13,2,...
  - (A,B) = (0,0),(1,0),(0,1),(1,1) for blk 0..3; blk 5 = (1,0); blk 10 = (0,1).
  - mb_done after 256 edges, 16 cavlc transfers.
- mb_x=3, mb_y=2: mbAddrA_valid=mbAddrB_valid=1 for all 16 blocks.
- cavlc_ready low 5 cycles at block 4: WAIT_CAVLC held 6 cycles, blk_idx=4 stable, cavlc_valid=1 throughout; mb_done delayed exactly 5 cycles (edge 261).
- DCT_LAT=1, IDCT_LAT=5: CNT_DCT lasts 1 cycle, CNT_IDCT 5; per-block path 15 cycles; mb_done at edge 256.
- h264_reset asserted in CNT_IDCT of block 9:
  - Next cycle IDLE, blk_idx=0, no mb_done.
  - A fresh start completes a full macroblock normally.
- start re-pulsed while busy at block 7: ignored. start held high across mb_done: next macroblock LOAD one cycle after returning to IDLE.
